// File: rtl/tdm_demultiplexer.sv
// Serial TDM receiver: locks to fsync and splits a 1-bit stream into 4 channel words.
// Optional TDM_PARITY_EN appends an even-parity bit to every slot and adds par_err.
module tdm_demultiplexer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 din,
    input  logic                 din_en,
    input  logic                 fsync,
    output logic [4*WIDTH-1:0]   out,
    output logic [3:0]           out_valid,
    output logic [1:0]           s,
    output logic                 locked,
`ifdef TDM_PARITY_EN
    output logic                 sync_err,
    output logic [3:0]           par_err
`else
    output logic                 sync_err
`endif
);

`ifdef TDM_PARITY_EN
    localparam int unsigned SLOT_LEN = WIDTH + 1;
`else
    localparam int unsigned SLOT_LEN = WIDTH;
`endif
    localparam int unsigned CW = $clog2(SLOT_LEN);

    typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

    state_t            state;
    logic [CW-1:0]     bitcnt;
    logic [WIDTH-1:0]  sr;
    logic [WIDTH-1:0]  word_done;

    // Inserts one serial bit into a partial word in transmission order.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic d);
        if (MSB_FIRST) begin
            return {cur[WIDTH-2:0], d};
        end
        return {d, cur[WIDTH-1:1]};
    endfunction

    // The slot-closing bit is either the last data bit or the parity bit.
`ifdef TDM_PARITY_EN
    assign word_done = sr;
`else
    assign word_done = shift_in(sr, din);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            bitcnt    <= '0;
            sr        <= '0;
            out       <= '0;
            out_valid <= '0;
            s         <= '0;
            locked    <= 1'b0;
            sync_err  <= 1'b0;
`ifdef TDM_PARITY_EN
            par_err   <= '0;
`endif
        end else begin
            out_valid <= '0;
            sync_err  <= 1'b0;
`ifdef TDM_PARITY_EN
            par_err   <= '0;
`endif
            if (din_en) begin
                case (state)
                    HUNT: begin
                        if (fsync) begin
                            state  <= LOCK;
                            locked <= 1'b1;
                            sr     <= shift_in(WIDTH'(0), din);
                            bitcnt <= CW'(1);
                            s      <= 2'd0;
                        end
                    end
                    LOCK: begin
                        if (bitcnt == '0 && s == 2'd0) begin
                            // Frame boundary: this bit must carry fsync.
                            if (fsync) begin
                                sr     <= shift_in(WIDTH'(0), din);
                                bitcnt <= CW'(1);
                            end else begin
                                sync_err <= 1'b1;
                                state    <= HUNT;
                                locked   <= 1'b0;
                                bitcnt   <= '0;
                                s        <= 2'd0;
                            end
                        end else if (fsync) begin
                            // Early fsync: drop the partial slot and realign.
                            sync_err <= 1'b1;
                            sr       <= shift_in(WIDTH'(0), din);
                            bitcnt   <= CW'(1);
                            s        <= 2'd0;
                        end else if (bitcnt == CW'(SLOT_LEN - 1)) begin
                            out[s*WIDTH +: WIDTH] <= word_done;
                            out_valid[s]          <= 1'b1;
`ifdef TDM_PARITY_EN
                            par_err[s]            <= (^sr) != din;
`endif
                            bitcnt <= '0;
                            s      <= s + 2'd1;
                        end else begin
                            sr     <= shift_in(sr, din);
                            bitcnt <= bitcnt + CW'(1);
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdm_demultiplexer.sv
// Directed bench for tdm_demultiplexer with a frame-position model and per-cycle compare.
module tb_tdm_demultiplexer;

    localparam int WIDTH = 8;
`ifdef TDM_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int SL = WIDTH + P;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic din = 1'b0;
    logic din_en = 1'b0;
    logic fsync = 1'b0;
    logic [4*WIDTH-1:0] out;
    logic [3:0] out_valid;
    logic [1:0] s;
    logic locked;
    logic sync_err;
`ifdef TDM_PARITY_EN
    logic [3:0] par_err;
`endif

    tdm_demultiplexer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_en(din_en), .fsync(fsync),
        .out(out), .out_valid(out_valid), .s(s), .locked(locked),
`ifdef TDM_PARITY_EN
        .sync_err(sync_err), .par_err(par_err)
`else
        .sync_err(sync_err)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: position of the next expected bit within the frame, -1 while hunting.
    int pos = -1;
    bit slot_bits[$];
    logic [WIDTH-1:0] m_out [4];
    logic [3:0] m_valid = '0;
    logic [3:0] m_par = '0;
    logic m_err = 1'b0;
    logic m_locked = 1'b0;
    logic [1:0] m_s = '0;

    initial for (int i = 0; i < 4; i++) m_out[i] = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos = -1;
            slot_bits.delete();
            for (int i = 0; i < 4; i++) m_out[i] = '0;
            m_valid = '0; m_par = '0; m_err = 1'b0; m_locked = 1'b0; m_s = '0;
        end else begin
            m_valid = '0; m_par = '0; m_err = 1'b0;
            if (din_en) begin
                if (pos < 0) begin
                    if (fsync) begin
                        slot_bits.delete(); slot_bits.push_back(din);
                        pos = 1; m_locked = 1'b1;
                    end
                end else if (pos == 0) begin
                    if (fsync) begin
                        slot_bits.delete(); slot_bits.push_back(din); pos = 1;
                    end else begin
                        m_err = 1'b1; m_locked = 1'b0; pos = -1; slot_bits.delete();
                    end
                end else if (fsync) begin
                    m_err = 1'b1;
                    slot_bits.delete(); slot_bits.push_back(din); pos = 1;
                end else begin
                    slot_bits.push_back(din);
                    pos = pos + 1;
                    if (slot_bits.size() == SL) begin
                        int slot;
                        logic [WIDTH-1:0] w;
                        bit par;
                        slot = (pos - 1) / SL;
                        par = 1'b0;
                        for (int i = 0; i < WIDTH; i++) begin
                            w[WIDTH-1-i] = slot_bits[i];
                            par = par ^ slot_bits[i];
                        end
                        m_out[slot] = w;
                        m_valid[slot] = 1'b1;
                        if (P == 1 && par != slot_bits[SL-1]) m_par[slot] = 1'b1;
                        slot_bits.delete();
                        pos = pos % (4 * SL);
                    end
                end
            end
            m_s = (pos < 0) ? 2'd0 : 2'((pos / SL) % 4);
        end
    end

    // Per-cycle compare plus pulse bookkeeping for the literal checks.
    int cyc = 0;
    int serr_cnt = 0;
    int par_cnt = 0;
    logic [3:0] pulse_q[$];
    int pulse_t[$];

    always @(negedge clk) begin
        cyc++;
        chk("out", 64'(out), 64'({m_out[3], m_out[2], m_out[1], m_out[0]}));
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("s", 64'(s), 64'(m_s));
        chk("locked", 64'(locked), 64'(m_locked));
        chk("sync_err", 64'(sync_err), 64'(m_err));
`ifdef TDM_PARITY_EN
        chk("par_err", 64'(par_err), 64'(m_par));
        if (par_err != '0) par_cnt++;
`endif
        if (out_valid != '0) begin
            pulse_q.push_back(out_valid);
            pulse_t.push_back(cyc);
        end
        if (sync_err) serr_cnt++;
    end

    task automatic tick(input logic en, input logic d, input logic f);
        @(posedge clk);
        #1;
        din_en = en; din = d; fsync = f;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
    endtask

    // Sends one slot MSB first; par_flip inverts the parity bit when present.
    task automatic send_word(input logic [7:0] w, input bit f, input bit gap, input bit par_flip);
        logic [7:0] wv;
        wv = w;
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, wv[7-i], f && i == 0);
            if (gap) idle(2);
        end
        if (P == 1) begin
            tick(1'b1, (^wv) ^ par_flip, 1'b0);
            if (gap) idle(2);
        end
    endtask

    task automatic clear_marks();
        pulse_q.delete(); pulse_t.delete(); serr_cnt = 0; par_cnt = 0;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        idle(3);
        chk("reset_out", 64'(out), 64'h0);
        chk("reset_locked", 64'(locked), 64'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Lock and one frame, continuous strobe.
        clear_marks();
        send_word(8'hA5, 1'b1, 1'b0, 1'b0);
        send_word(8'h3C, 1'b0, 1'b0, 1'b0);
        send_word(8'hFF, 1'b0, 1'b0, 1'b0);
        send_word(8'h00, 1'b0, 1'b0, 1'b0);
        idle(2);
        chk("frame1_out", 64'(out), 64'h00FF3CA5);
        chk("frame1_locked", 64'(locked), 64'h1);
        chk("frame1_npulse", 64'(pulse_q.size()), 64'd4);
        if (pulse_q.size() == 4) begin
            chk("frame1_p0", 64'(pulse_q[0]), 64'h1);
            chk("frame1_p1", 64'(pulse_q[1]), 64'h2);
            chk("frame1_p2", 64'(pulse_q[2]), 64'h4);
            chk("frame1_p3", 64'(pulse_q[3]), 64'h8);
            chk("frame1_gap01", 64'(pulse_t[1] - pulse_t[0]), 64'(SL));
            chk("frame1_gap23", 64'(pulse_t[3] - pulse_t[2]), 64'(SL));
        end

        // Gapped strobe frame.
        clear_marks();
        send_word(8'h11, 1'b1, 1'b1, 1'b0);
        send_word(8'h22, 1'b0, 1'b1, 1'b0);
        send_word(8'h33, 1'b0, 1'b1, 1'b0);
        send_word(8'h44, 1'b0, 1'b1, 1'b0);
        idle(2);
        chk("gap_out", 64'(out), 64'h44332211);
        chk("gap_npulse", 64'(pulse_q.size()), 64'd4);
        chk("gap_serr", 64'(serr_cnt), 64'd0);

        // Missing fsync at the frame boundary.
        clear_marks();
        send_word(8'h55, 1'b0, 1'b0, 1'b0);
        send_word(8'h66, 1'b0, 1'b0, 1'b0);
        idle(2);
        chk("miss_serr", 64'(serr_cnt), 64'd1);
        chk("miss_locked", 64'(locked), 64'h0);
        chk("miss_out", 64'(out), 64'h44332211);
        chk("miss_npulse", 64'(pulse_q.size()), 64'd0);

        // Early fsync on bit 3 of slot 2.
        send_word(8'hA5, 1'b1, 1'b0, 1'b0);
        send_word(8'h3C, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        idle(1);
        clear_marks();
        send_word(8'h5A, 1'b1, 1'b0, 1'b0);
        idle(2);
        chk("early_serr", 64'(serr_cnt), 64'd1);
        chk("early_out", 64'(out), 64'h44333C5A);
        chk("early_locked", 64'(locked), 64'h1);
        chk("early_npulse", 64'(pulse_q.size()), 64'd1);
        if (pulse_q.size() == 1) chk("early_pulse", 64'(pulse_q[0]), 64'h1);

        // Reset in the middle of slot 1.
        send_word(8'h12, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'(i & 1), 1'b0);
        @(posedge clk); #1 rst_n = 1'b0; din_en = 1'b0;
        #1;
        chk("rst_async_out", 64'(out), 64'h0);
        chk("rst_async_locked", 64'(locked), 64'h0);
        chk("rst_async_s", 64'(s), 64'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        clear_marks();
        send_word(8'h77, 1'b0, 1'b0, 1'b0);
        idle(2);
        chk("rst_nolock_out", 64'(out), 64'h0);
        chk("rst_nolock_pulse", 64'(pulse_q.size()), 64'd0);
        send_word(8'hDE, 1'b1, 1'b0, 1'b0);
        send_word(8'hAD, 1'b0, 1'b0, 1'b0);
        send_word(8'hBE, 1'b0, 1'b0, 1'b0);
        send_word(8'hEF, 1'b0, 1'b0, 1'b0);
        idle(2);
        chk("rst_frame_out", 64'(out), 64'hEFBEADDE);

`ifdef TDM_PARITY_EN
        // Bad then good parity on slot 0.
        clear_marks();
        send_word(8'h07, 1'b1, 1'b0, 1'b1);
        idle(2);
        chk("par_bad_word", 64'(out[7:0]), 64'h07);
        chk("par_bad_cnt", 64'(par_cnt), 64'd1);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        clear_marks();
        send_word(8'h07, 1'b1, 1'b0, 1'b0);
        idle(2);
        chk("par_good_word", 64'(out[7:0]), 64'h07);
        chk("par_good_cnt", 64'(par_cnt), 64'd0);
`endif

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
